// File: rtl/iter_down_sequencer_pkg.sv
// Shared definitions for the iteration sequencers: FSM state encoding and default width.
package iter_down_sequencer_pkg;

  localparam int SEQ_BIT_LENGTH = 16;

  typedef logic [1:0] seq_state_t;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/iter_down_sequencer_if.sv
// Controller <-> sequencer bundle: start/budget/advance/cancel requests and status back.
interface iter_down_sequencer_if
  import iter_down_sequencer_pkg::*;
#(
  parameter int BIT_LENGTH = SEQ_BIT_LENGTH
);
  logic                  start;
  logic [BIT_LENGTH-1:0] load_val;
  logic                  en_cnt;
  logic                  abort;
  logic [BIT_LENGTH-1:0] count;
  logic [BIT_LENGTH-1:0] index;
  logic                  busy;
  logic                  last;
  logic                  zero;
  logic                  done;

  modport master (
    output start, load_val, en_cnt, abort,
    input  count, index, busy, last, zero, done
  );

  modport slave (
    input  start, load_val, en_cnt, abort,
    output count, index, busy, last, zero, done
  );
endinterface

// File: rtl/iter_down_sequencer_down_counter_re.sv
// Loadable down counter with async active-low reset; load takes priority over enable.
module down_counter_re #(
  parameter int BIT_LENGTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIT_LENGTH-1:0] load_val,
  input  logic                  en,
  output logic [BIT_LENGTH-1:0] count,
  output logic                  zero
);

  // Count register: load wins, otherwise decrement when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - BIT_LENGTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iter_down_sequencer.sv
// Down-counting iteration sequencer: loads a budget N, counts it to zero, pulses done.
module iter_down_sequencer
  import iter_down_sequencer_pkg::*;
#(
  parameter int BIT_LENGTH = SEQ_BIT_LENGTH
) (
  input  logic               clk,
  input  logic               rst,
  iter_down_sequencer_if.slave bus
);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic                  accept_start;
  logic                  abort_run;
  logic                  step;
  logic                  cnt_load;
  logic [BIT_LENGTH-1:0] cnt_load_val;
  logic [BIT_LENGTH-1:0] cnt_q;
  logic                  cnt_zero;
  logic [BIT_LENGTH-1:0] index_q;

  // Abort beats an advance; start is only honoured from IDLE.
  assign accept_start = (state_q == IDLE) && bus.start;
  assign abort_run    = (state_q == RUN) && bus.abort;
  assign step         = (state_q == RUN) && bus.en_cnt && !bus.abort;

  // An abort reuses the load path to force the remaining count back to zero.
  assign cnt_load     = accept_start || abort_run;
  assign cnt_load_val = accept_start ? bus.load_val : '0;

  down_counter_re #(
    .BIT_LENGTH(BIT_LENGTH)
  ) u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (step),
    .count    (cnt_q),
    .zero     (cnt_zero)
  );

  // Next-state logic; a zero budget goes straight to DONE so done still fires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.load_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.en_cnt && (cnt_q == BIT_LENGTH'(1))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Elapsed index: cleared on start, bumped per step, held through abort and DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q <= '0;
    end else if (accept_start) begin
      index_q <= '0;
    end else if (step) begin
      index_q <= index_q + BIT_LENGTH'(1);
    end
  end

  assign bus.count = cnt_q;
  assign bus.index = index_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.last  = (state_q == RUN) && (cnt_q == BIT_LENGTH'(1));
  assign bus.zero  = cnt_zero;
  assign bus.done  = (state_q == DONE);

endmodule
